// File: rtl/fifo_word_packer_pkg.sv
// Shared definitions for the RAM FIFO drain side: FIFO read handshake
// timing, lane ordering of packed words and the packer's load selection.
package fifo_word_packer_pkg;

   // FIFO read contract: rdata for a pop (shift_out=1) is valid exactly
   // this many cycles later, and empty reflects the pop by then as well.
   localparam int FIFO_RD_LATENCY = 1;

   // Source of the word loaded into the output register in a given cycle.
   typedef enum logic [1:0] {
      LOAD_NONE    = 2'd0,  // output register keeps its content
      LOAD_DIRECT  = 2'd1,  // completing word bypasses assembly into output
      LOAD_GROUP   = 2'd2,  // full group parked in assembly moves to output
      LOAD_PARTIAL = 2'd3   // flush emits a partially filled group
   } load_e;

   // Lane order: the first word of a group is lane 0 (least significant
   // bits), later words fill successively higher lanes. A lane carries
   // data only when its index is below the group's word count.
   function automatic logic lane_used(input int lane, input int count);
      return (lane < count);
   endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drain stage for the RAM FIFO: pops WIDTH-bit words, packs RATIO of them
// (lane 0 = first word) into one wide word and offers it on a valid/ready
// stream. A flush request pushes out a partially filled group.
module fifo_word_packer
   import fifo_word_packer_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int RATIO = 4,
   localparam int CNT_W = $clog2(RATIO + 1)
) (
   input  logic                   clk,
   input  logic                   res_n,
   input  logic                   fifo_empty,
   input  logic [WIDTH-1:0]       fifo_rdata,
   output logic                   fifo_shift_out,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*RATIO-1:0] out_data,
   output logic [CNT_W-1:0]       out_count
);

   // Tracks the single pop in flight; the FIFO returns data one cycle later.
   localparam int PEND_DEPTH = FIFO_RD_LATENCY;

   // Control state
   logic [CNT_W-1:0]              r_cnt;         // lanes filled in assembly
   logic [PEND_DEPTH-1:0]         r_pend;        // pop issued last cycle
   logic                          r_flush_pend;  // latched flush request
   logic                          r_out_valid;
   logic [WIDTH*RATIO-1:0]        r_out_data;
   logic [CNT_W-1:0]              r_out_count;

   // Combinational helpers
   logic                          w_arrive;      // FIFO word on rdata now
   logic                          w_out_free;    // output reg can load at this edge
   logic [CNT_W:0]                w_inflight;    // cnt + pend
   logic                          w_room;
   logic                          w_full_arrive; // arrival completes the group
   logic                          w_flush_done;
   load_e                         w_load;
   logic [CNT_W-1:0]              w_emit_count;
   logic [CNT_W-1:0]              w_cnt_nxt;
   logic [RATIO-1:0][WIDTH-1:0]   w_group;
   logic [RATIO-1:0][WIDTH-1:0]   w_emit_data;

   assign w_arrive      = r_pend[PEND_DEPTH-1];
   assign w_out_free    = !r_out_valid || out_ready;
   assign w_inflight    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_arrive};
   assign w_full_arrive = w_arrive && (r_cnt == CNT_W'(RATIO - 1));

   // A new pop needs a free lane for its word. When the in-flight word fills
   // the last lane, the next pop may still go out if that completed group
   // can leave straight for the output register, making lane 0 free.
   assign w_room = (w_inflight < (CNT_W + 1)'(RATIO)) ||
                   ((w_inflight == (CNT_W + 1)'(RATIO)) && w_arrive && w_out_free);

   // Pops are held off while a flush is pending and forced low in reset.
   assign fifo_shift_out = res_n && !fifo_empty && !r_flush_pend && w_room;

   // A pending flush resolves once nothing is in flight and the output
   // register can accept; with an empty assembly it simply disappears.
   assign w_flush_done = r_flush_pend && !w_arrive && w_out_free;

   // Pick what, if anything, loads the output register this cycle and how
   // the lane counter moves.
   always_comb begin
      w_load       = LOAD_NONE;
      w_emit_count = CNT_W'(RATIO);
      w_cnt_nxt    = r_cnt;
      if (w_full_arrive && w_out_free) begin
         w_load    = LOAD_DIRECT;
         w_cnt_nxt = '0;
      end else if (!w_arrive && (r_cnt == CNT_W'(RATIO)) && w_out_free) begin
         w_load    = LOAD_GROUP;
         w_cnt_nxt = '0;
      end else if (w_flush_done && (r_cnt != '0)) begin
         w_load       = LOAD_PARTIAL;
         w_emit_count = r_cnt;
         w_cnt_nxt    = '0;
      end else if (w_arrive) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   // One assembly lane per FIFO word position in the group.
   for (genvar g = 0; g < RATIO; g++) begin : g_lane
      logic [WIDTH-1:0] r_lane;
      logic             w_we;

      assign w_we = w_arrive && (r_cnt == CNT_W'(g));

      // Capture the arriving FIFO word into the lane it was destined for.
      always_ff @(posedge clk) begin
         if (w_we) r_lane <= fifo_rdata;
      end

      // The arriving word is visible in its lane in the same cycle so a
      // completing group can go straight to the output register.
      assign w_group[g]     = w_we ? fifo_rdata : r_lane;
      assign w_emit_data[g] = lane_used(g, int'(w_emit_count)) ? w_group[g] : '0;
   end

   // Pop tracking, lane count and flush latch.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_cnt        <= '0;
         r_pend       <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_pend       <= PEND_DEPTH'(fifo_shift_out);
         r_flush_pend <= (r_flush_pend && !w_flush_done) || flush;
      end
   end

   // Output stream register: load a new word, or drop valid on handshake;
   // otherwise hold data and count stable.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
      end else if (w_load != LOAD_NONE) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_emit_data;
         r_out_count <= w_emit_count;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_count = r_out_count;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a behavioural FIFO feeds the packer, pushed
// words build expected output groups in a scoreboard, and every handshake
// on the output stream is compared against the scoreboard head.
module tb_fifo_word_packer;
   localparam int WIDTH = 8;
   localparam int RATIO = 4;
   localparam int CNT_W = $clog2(RATIO + 1);
   localparam int OW    = WIDTH * RATIO;

   logic             clk = 1'b0;
   logic             res_n;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_shift_out;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [OW-1:0]    out_data;
   logic [CNT_W-1:0] out_count;

   always #5 clk = ~clk;

   fifo_word_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
      .clk           (clk),
      .res_n         (res_n),
      .fifo_empty    (fifo_empty),
      .fifo_rdata    (fifo_rdata),
      .fifo_shift_out(fifo_shift_out),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_count     (out_count)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [WIDTH-1:0] fq[$];        // FIFO contents
   logic [OW-1:0]    exp_data[$];  // scoreboard
   int               exp_cnt[$];
   logic [OW-1:0]    acc;          // group being assembled by the model
   int               acc_n;
   int               pop_cycs[$];
   int               out_cycs[$];
   logic             prev_stall;
   logic [OW-1:0]    prev_data;
   logic [CNT_W-1:0] prev_count;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      fq.push_back(w);
      fifo_empty = 1'b0;
      acc = acc | (OW'(w) << (acc_n * WIDTH));
      acc_n++;
      if (acc_n == RATIO) begin
         exp_data.push_back(acc);
         exp_cnt.push_back(RATIO);
         acc   = '0;
         acc_n = 0;
      end
   endtask

   task automatic flush_model();
      if (acc_n > 0) begin
         exp_data.push_back(acc);
         exp_cnt.push_back(acc_n);
      end
      acc   = '0;
      acc_n = 0;
   endtask

   task automatic clear_model();
      fq.delete();
      exp_data.delete();
      exp_cnt.delete();
      acc        = '0;
      acc_n      = 0;
      fifo_empty = 1'b1;
      prev_stall = 1'b0;
   endtask

   // One clock cycle: observe at the falling edge, update the FIFO model
   // just after the rising edge. Inputs changed by the caller afterwards
   // apply to the next cycle.
   task automatic tick();
      logic          s;
      logic [OW-1:0] ed;
      int            ec;
      @(negedge clk);
      s = fifo_shift_out;
      if (s) begin
         pop_cycs.push_back(cyc);
         if (fq.size() == 0) chk("pop_on_empty", 64'(s), 64'(0));
      end
      if (prev_stall) begin
         chk("hold_valid", 64'(out_valid), 64'(1));
         chk("hold_data", 64'(out_data), 64'(prev_data));
         chk("hold_count", 64'(out_count), 64'(prev_count));
      end
      if (out_valid && out_ready) begin
         out_cycs.push_back(cyc);
         if (exp_data.size() == 0) begin
            chk("spurious_valid", 64'(out_valid), 64'(0));
         end else begin
            ed = exp_data.pop_front();
            ec = exp_cnt.pop_front();
            chk("out_data", 64'(out_data), 64'(ed));
            chk("out_count", 64'(out_count), 64'(ec));
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_count = out_count;
      @(posedge clk);
      #1;
      if (s && fq.size() > 0) fifo_rdata = fq.pop_front();
      fifo_empty = (fq.size() == 0);
      cyc++;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_data"}, 64'(out_data), 64'(0));
      chk({tag, "_count"}, 64'(out_count), 64'(0));
      chk({tag, "_pop"}, 64'(fifo_shift_out), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int pc;
      int guard;
      res_n      = 1'b0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      fifo_rdata = '0;
      clear_model();

      // Reset with eight words waiting, then back-to-back packing.
      for (int i = 1; i <= 8; i++) push_word(WIDTH'(i));
      #1;
      check_zero_outputs("reset");
      tick();
      tick();
      chk("reset_no_pop", 64'(pop_cycs.size()), 64'(0));
      res_n = 1'b1;
      pop_cycs.delete();
      out_cycs.delete();
      guard = 0;
      while (out_cycs.size() < 2 && guard < 30) begin
         tick();
         guard++;
      end
      repeat (10) tick();
      chk("lat_outputs", 64'(out_cycs.size()), 64'(2));
      chk("lat_pops", 64'(pop_cycs.size()), 64'(8));
      if (out_cycs.size() >= 2 && pop_cycs.size() >= 8) begin
         chk("lat_first", 64'(out_cycs[0] - pop_cycs[0]), 64'(RATIO + 1));
         chk("lat_second", 64'(out_cycs[1] - out_cycs[0]), 64'(RATIO));
         chk("pop_no_bubble", 64'(pop_cycs[7] - pop_cycs[0]), 64'(7));
      end
      chk("sb_empty_t1", 64'(exp_data.size()), 64'(0));

      // Partial word forced out by flush; popping held until flush resolves.
      push_word(8'hA1);
      push_word(8'hA2);
      push_word(8'hA3);
      repeat (6) tick();
      flush = 1'b1;
      flush_model();
      tick();
      flush = 1'b0;
      for (int i = 1; i <= 4; i++) push_word(8'hB0 + WIDTH'(i));
      pop_cycs.delete();
      pc = cyc;
      repeat (16) tick();
      chk("flush_pops", 64'(pop_cycs.size()), 64'(4));
      if (pop_cycs.size() > 0) chk("flush_resume", 64'(pop_cycs[0]), 64'(pc + 1));
      chk("sb_empty_t2", 64'(exp_data.size()), 64'(0));

      // Backpressure with the FIFO full.
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) push_word(8'h30 + WIDTH'(i));
      pop_cycs.delete();
      repeat (14) tick();
      chk("bp_pops", 64'(pop_cycs.size()), 64'(2 * RATIO));
      chk("bp_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      repeat (20) tick();
      chk("bp_pops_total", 64'(pop_cycs.size()), 64'(3 * RATIO));
      chk("sb_empty_t3", 64'(exp_data.size()), 64'(0));

      // Flush with nothing assembled and nothing in flight.
      flush = 1'b1;
      flush_model();
      tick();
      flush = 1'b0;
      repeat (3) tick();
      for (int i = 1; i <= 4; i++) push_word(8'hD0 + WIDTH'(i));
      pop_cycs.delete();
      pc = cyc;
      repeat (12) tick();
      chk("idle_flush_pops", 64'(pop_cycs.size()), 64'(4));
      if (pop_cycs.size() > 0) chk("idle_flush_resume", 64'(pop_cycs[0]), 64'(pc));
      chk("sb_empty_t4", 64'(exp_data.size()), 64'(0));

      // Flush in the same cycle the fourth word arrives.
      for (int i = 1; i <= 4; i++) push_word(8'hE0 + WIDTH'(i));
      pop_cycs.delete();
      guard = 0;
      while (pop_cycs.size() < 4 && guard < 10) begin
         tick();
         guard++;
      end
      chk("coinc_pops", 64'(pop_cycs.size()), 64'(4));
      flush = 1'b1;
      flush_model();
      tick();
      flush = 1'b0;
      repeat (10) tick();
      chk("sb_empty_t5", 64'(exp_data.size()), 64'(0));

      // Reset with two lanes filled and a pop in flight.
      push_word(8'hF1);
      push_word(8'hF2);
      push_word(8'hF3);
      pop_cycs.delete();
      guard = 0;
      while (pop_cycs.size() < 3 && guard < 10) begin
         tick();
         guard++;
      end
      chk("mid_pops", 64'(pop_cycs.size()), 64'(3));
      res_n = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      clear_model();
      tick();
      tick();
      res_n = 1'b1;
      for (int i = 1; i <= 4; i++) push_word(8'hC0 + WIDTH'(i));
      repeat (12) tick();
      chk("sb_empty_t6", 64'(exp_data.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream drain stage for the team's RAM-based FIFO. It pops WIDTH-bit words through the FIFO's `shift_out`/`empty`/`rdata` interface. It packs RATIO consecutive words into one wide word and presents that word on a valid/ready stream. A flush input forces out a partially filled word, so trailing data is never stranded.

## Interface
- `WIDTH`, 8, width of one FIFO word
- `RATIO`, 4, FIFO words per output word (≥2)
- `clk`  in  1  single clock, rising edge
- `res_n`  in  1  asynchronous, active-low reset
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rdata`  in  WIDTH  FIFO read data, valid the cycle after a pop
- `fifo_shift_out`  out  1  pop request to FIFO
- `flush`  in  1  request emission of a partial word
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  WIDTH*RATIO  packed word
- `out_count`  out  clog2(RATIO+1)  words valid in `out_data` (1..RATIO)

## Operation
- FIFO contract:
  - A pop is a cycle with `fifo_shift_out=1`.
  - `fifo_rdata` for that pop is valid exactly one cycle later.
  - `fifo_empty` reflects each pop by the following cycle.
- Internal state:
  - assembly register, RATIO lanes
  - `cnt` (0..RATIO), lanes filled
  - `pend` (0/1), pop in flight
  - `flush_pend`, latched flush request
  - output register with `out_valid`/`out_count`
- Lane order: the first word of a group goes to bits [WIDTH-1:0], and each subsequent word goes to the next lane up.
- Pop issue: `fifo_shift_out = !fifo_empty && !flush_pend && room`. `room` is true when either:
  - `cnt+pend < RATIO`, or
  - `cnt+pend == RATIO`, `pend==1`, and the output register is free next cycle (`!out_valid || out_ready`). The new word then becomes lane 0 of the next group.
- Word arrival (cycle after a pop): the word is written to lane `cnt`.
  - If it completes the group and the output register is free next cycle, load the output register directly: `out_count=RATIO`, `cnt` returns to 0.
  - Otherwise the word stays in the assembly register with `cnt=RATIO`, and popping stalls.
- A completed group in the assembly register transfers to the output register when `!out_valid || out_ready`.
- Flush:
  - `flush` sets `flush_pend`, which blocks new pops.
  - Once `pend==0` and the output register is free:
    - `cnt>0`: emit the assembly lanes with `out_count=cnt`, zero the unused upper lanes, set `cnt=0`, clear `flush_pend`.
    - `cnt==0`: clear `flush_pend` and emit nothing.
- The stream handshake completes on `out_valid && out_ready`.
  - `out_data`/`out_count` hold stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_count=0`
  - `cnt=0`, `pend=0`, `flush_pend=0`
  - `fifo_shift_out=0` while `res_n` is low
- Reset mid-operation discards in-flight and partial words; the FIFO shares the same reset.
- Latency: with back-to-back pops starting at cycle t, `out_valid` is asserted in cycle t+RATIO+1.
- Throughput: with `out_ready` held high and the FIFO non-empty, one output word every RATIO cycles, with no pop bubbles.
- Flush is sampled every cycle. A flush that arrives while a word is in flight waits for the arrival, and that word is included in the partial output.
- Flush and a completing arrival in the same cycle: the full group is emitted first (`out_count=RATIO`). The flush then finds `cnt==0` and emits nothing.
- Backpressure: with `out_valid=1`, `out_ready=0` and the assembly register full, `fifo_shift_out` stays 0.

## Structure
- Single module; no sub-module needed.
- `CNT_W = $clog2(RATIO+1)` is a local parameter.
- The FIFO handshake timing and the lane-order definition belong in the team's shared FIFO include/package, so the FIFO and this packer use one source.
- The assembly lane writes are a generate loop over RATIO.

## Test plan
- Reset with FIFO holding 8 words `0x01..0x08`, RATIO=4, `out_ready=1`:
  - required: `out_data=0x04030201` at t+5, then `0x08070605` exactly 4 cycles later.
  - required: no further `out_valid`.
- 3 words `0xA1,0xA2,0xA3`, then `flush` pulse:
  - required: `out_data=0x00A3A2A1`, `out_count=3`.
  - required: popping resumes only after `flush_pend` clears.
- `out_ready=0` for 10 cycles with FIFO full:
  - required: `out_data` stable.
  - required: exactly 2·RATIO pops total, then `fifo_shift_out=0` until `out_ready` rises.
- `flush` with `cnt==0` and no word in flight:
  - required: no `out_valid` and no pop suppression afterwards.
- Flush asserted in the same cycle as the 4th word's arrival:
  - required: one full word with `out_count=4` and no extra empty word.
- `res_n` pulsed low with 2 lanes filled and a pop in flight:
  - required: all outputs are 0 immediately.
  - required: after release, the next word starts at lane 0.
